// File: rtl/oscilo_pkg.sv
// Shared definitions for the oscilloscope capture/readback blocks: state
// watcher codes, the sample reader state type and the frame sync byte.
package oscilo_pkg;

    // State watcher code that selects the sample reader.
    localparam logic [7:0] ST_SAMPLE_READ = 8'h22;

    // First byte of every readback frame.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        SR_IDLE,
        SR_HDR,
        SR_HDR_WAIT,
        SR_FETCH,
        SR_XMIT,
        SR_XMIT_WAIT,
        SR_CSUM,
        SR_CSUM_WAIT,
        SR_DONE
    } sample_reader_state_t;

    // Running frame checksum: plain 8-bit sum, wrapping mod 256.
    function automatic logic [7:0] checksum_add(input logic [7:0] sum,
                                                input logic [7:0] sample);
        return sum + sample;
    endfunction

endpackage

// File: rtl/uart_byte_sender.sv
// Hands one byte to uart_tx: while load is held it waits for the
// transmitter to go idle, then latches the byte and raises tx_start for a
// single cycle. sent simply forwards tx_done; the caller decides when a
// tx_done belongs to its byte.
module uart_byte_sender
    import oscilo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       issued,
    output logic       sent
);

    // The caller drops load on the cycle after issued, so tx_start can never
    // be high on two consecutive cycles.
    assign issued = load && !tx_active;
    assign sent   = tx_done;

    // Register the byte and the one-cycle start pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            tx_start <= issued;
            if (issued) begin
                tx_data <= data;
            end
        end
    end

endmodule

// File: rtl/sample_reader.sv
// Streams the whole sample memory to the host after a capture: sync byte,
// every sample from address 0 upward, then an optional 8-bit checksum.
// Runs while the state watcher holds activate high; dropping activate
// mid-frame abandons the frame and the next activation starts over.
module sample_reader
    import oscilo_pkg::*;
#(
    parameter int         DATA_WIDTH    = 8,
    parameter int         ADDR_WIDTH    = 8,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
    parameter bit         SEND_CHECKSUM = 1'b1
) (
    input  logic                  clk_50mhz,
    input  logic                  reset,
    input  logic                  activate,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_active,
    input  logic                  tx_done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(1);

    sample_reader_state_t state;
    logic [7:0]           checksum;
    logic                 load;
    logic [7:0]           load_byte;
    logic                 issued;
    logic                 sent;

    // Pick which byte is offered to the sender in each sending state.
    always_comb begin
        load      = 1'b0;
        load_byte = SYNC_BYTE;
        unique case (state)
            SR_HDR: begin
                load = activate;
            end
            SR_XMIT: begin
                load      = activate;
                load_byte = mem_data[7:0];
            end
            SR_CSUM: begin
                load      = activate;
                load_byte = checksum;
            end
            default: begin
            end
        endcase
    end

    uart_byte_sender sender (
        .clk       (clk_50mhz),
        .reset     (reset),
        .load      (load),
        .data      (load_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .issued    (issued),
        .sent      (sent)
    );

    // Frame sequencer: walks header, samples and checksum, one byte per
    // tx_done, with abort on activate falling.
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state    <= SR_IDLE;
            done     <= 1'b0;
            mem_addr <= '0;
            mem_oe   <= 1'b0;
            checksum <= 8'h00;
        end else if (!activate && state != SR_IDLE && state != SR_DONE) begin
            state  <= SR_IDLE;
            mem_oe <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                SR_IDLE: begin
                    if (activate) begin
                        state    <= SR_HDR;
                        mem_addr <= '0;
                        checksum <= 8'h00;
                    end
                end
                SR_HDR: begin
                    if (issued) begin
                        state <= SR_HDR_WAIT;
                    end
                end
                SR_HDR_WAIT: begin
                    if (sent) begin
                        state  <= SR_FETCH;
                        mem_oe <= 1'b1;
                    end
                end
                // One settling cycle for the asynchronous memory read.
                SR_FETCH: begin
                    state <= SR_XMIT;
                end
                SR_XMIT: begin
                    if (issued) begin
                        checksum <= checksum_add(checksum, mem_data[7:0]);
                        mem_oe   <= 1'b0;
                        state    <= SR_XMIT_WAIT;
                    end
                end
                SR_XMIT_WAIT: begin
                    if (sent) begin
                        if (&mem_addr) begin
                            if (SEND_CHECKSUM) begin
                                state <= SR_CSUM;
                            end else begin
                                state <= SR_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            mem_addr <= mem_addr + ADDR_STEP;
                            mem_oe   <= 1'b1;
                            state    <= SR_FETCH;
                        end
                    end
                end
                SR_CSUM: begin
                    if (issued) begin
                        state <= SR_CSUM_WAIT;
                    end
                end
                SR_CSUM_WAIT: begin
                    if (sent) begin
                        state <= SR_DONE;
                        done  <= 1'b1;
                    end
                end
                SR_DONE: begin
                    if (!activate) begin
                        state <= SR_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state  <= SR_IDLE;
                    done   <= 1'b0;
                    mem_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_reader.sv
// Bench for sample_reader: three instances (default, 4-sample with
// checksum, 4-sample without checksum), a behavioural UART transmitter
// with random byte times, and a frame model built from memory contents.
module tb_sample_reader;
    import oscilo_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic       clk_50mhz = 1'b0;
    logic       reset;
    logic [2:0] act;
    logic [2:0] force_busy;
    logic [2:0] busy;
    logic [2:0] proto_err;
    logic [2:0] done_w;
    logic [2:0] tx_start_w;
    logic [2:0] tx_active_w;
    logic [2:0] tx_done_w;
    logic [2:0] mem_oe_w;
    logic [7:0] tx_data_w [3];
    int         cnt [3];

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [4];
    logic [7:0] mem2 [4];
    logic [7:0] mem_addr0;
    logic [1:0] mem_addr1;
    logic [1:0] mem_addr2;
    logic [7:0] mem_data0;
    logic [7:0] mem_data1;
    logic [7:0] mem_data2;

    logic [9:0] rx_log[$];

    int vectors     = 0;
    int miscompares = 0;

    always #10 clk_50mhz = ~clk_50mhz;

    assign mem_data0 = mem0[mem_addr0];
    assign mem_data1 = mem1[mem_addr1];
    assign mem_data2 = mem2[mem_addr2];

    always_comb begin
        tx_active_w = busy | force_busy;
    end

    sample_reader dut_def (
        .clk_50mhz(clk_50mhz), .reset(reset), .activate(act[0]), .done(done_w[0]),
        .mem_addr(mem_addr0), .mem_oe(mem_oe_w[0]), .mem_data(mem_data0),
        .tx_data(tx_data_w[0]), .tx_start(tx_start_w[0]),
        .tx_active(tx_active_w[0]), .tx_done(tx_done_w[0])
    );

    sample_reader #(.ADDR_WIDTH(2)) dut_a2 (
        .clk_50mhz(clk_50mhz), .reset(reset), .activate(act[1]), .done(done_w[1]),
        .mem_addr(mem_addr1), .mem_oe(mem_oe_w[1]), .mem_data(mem_data1),
        .tx_data(tx_data_w[1]), .tx_start(tx_start_w[1]),
        .tx_active(tx_active_w[1]), .tx_done(tx_done_w[1])
    );

    sample_reader #(.ADDR_WIDTH(2), .SEND_CHECKSUM(1'b0)) dut_nc (
        .clk_50mhz(clk_50mhz), .reset(reset), .activate(act[2]), .done(done_w[2]),
        .mem_addr(mem_addr2), .mem_oe(mem_oe_w[2]), .mem_data(mem_data2),
        .tx_data(tx_data_w[2]), .tx_start(tx_start_w[2]),
        .tx_active(tx_active_w[2]), .tx_done(tx_done_w[2])
    );

    // UART transmitter model: accepts a start only when idle, logs the byte,
    // stays busy a random number of cycles, then pulses tx_done as it idles.
    initial begin
        busy      = '0;
        proto_err = '0;
        tx_done_w = '0;
        for (int k = 0; k < 3; k++) cnt[k] = 0;
    end

    always @(posedge clk_50mhz) begin
        for (int k = 0; k < 3; k++) begin
            tx_done_w[k] <= 1'b0;
            if (tx_start_w[k]) begin
                if (busy[k] || force_busy[k]) begin
                    proto_err[k] <= 1'b1;
                end else begin
                    busy[k] <= 1'b1;
                    cnt[k]  <= int'($urandom_range(2, 10));
                    rx_log.push_back({2'(k), tx_data_w[k]});
                end
            end else if (busy[k]) begin
                if (cnt[k] == 0) begin
                    busy[k]      <= 1'b0;
                    tx_done_w[k] <= 1'b1;
                end else begin
                    cnt[k] <= cnt[k] - 1;
                end
            end
        end
    end

    task automatic collect(input int k, input int base, output byte_q_t q);
        q = {};
        for (int i = base; i < rx_log.size(); i++) begin
            if (rx_log[i][9:8] == 2'(k)) q.push_back(rx_log[i][7:0]);
        end
    endtask

    task automatic wait_done(input int k, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk_50mhz);
            #1;
            if (done_w[k]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_act(input int k);
        act[k] = 1'b0;
        repeat (3) @(posedge clk_50mhz);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #5;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({done_w[k], tx_start_w[k], mem_oe_w[k]} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_ctrl[%0d] got done/start/oe=%b want 000", k,
                         {done_w[k], tx_start_w[k], mem_oe_w[k]});
            end
        end
        vectors++;
        if ({mem_addr0, mem_addr1, mem_addr2, tx_data_w[0]} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_addr got addr0=%h addr1=%h addr2=%h data=%h want 0",
                     mem_addr0, mem_addr1, mem_addr2, tx_data_w[0]);
        end
        repeat (2) @(negedge clk_50mhz);
        reset = 1'b1;
        repeat (2) @(posedge clk_50mhz);
        #1;
    endtask

    task automatic test_default_frame(input bit random_mem);
        byte_q_t exp, got;
        int      base, s;
        bit      ok;
        s = 0;
        exp = {SYNC_BYTE_DEFAULT};
        for (int i = 0; i < 256; i++) begin
            mem0[i] = random_mem ? 8'($urandom) : 8'(i);
            exp.push_back(mem0[i]);
            s += int'(mem0[i]);
        end
        exp.push_back(8'(s % 256));
        base   = rx_log.size();
        act[0] = 1'b1;
        wait_done(0, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL default_done got timeout want done=1");
        end
        collect(0, base, got);
        vectors++;
        if (got.size() != exp.size() || proto_err[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL default_starts got %0d starts (proto_err=%b) want %0d",
                     got.size(), proto_err[0], exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL default_byte[%0d] got %h want %h", i, got[i], exp[i]);
            end
        end
        release_act(0);
    endtask

    task automatic test_small_checksum();
        byte_q_t exp, got;
        int      base, s;
        bit      ok;
        mem1 = '{8'h10, 8'h20, 8'h30, 8'h40};
        s = 0;
        exp = {SYNC_BYTE_DEFAULT};
        for (int i = 0; i < 4; i++) begin
            exp.push_back(mem1[i]);
            s += int'(mem1[i]);
        end
        exp.push_back(8'(s % 256));
        base   = rx_log.size();
        act[1] = 1'b1;
        wait_done(1, ok);
        collect(1, base, got);
        vectors++;
        if (!ok || got.size() != exp.size()) begin
            miscompares++;
            $display("FAIL small_frame got done=%b len=%0d want done=1 len=%0d",
                     ok, got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL small_byte[%0d] got %h want %h", i, got[i], exp[i]);
            end
        end
        repeat (5) @(posedge clk_50mhz);
        #1;
        vectors++;
        if (done_w[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL small_done_hold got %b want 1", done_w[1]);
        end
        act[1] = 1'b0;
        @(posedge clk_50mhz);
        #1;
        vectors++;
        if (done_w[1] !== 1'b0 || dut_a2.state !== SR_IDLE) begin
            miscompares++;
            $display("FAIL small_release got done=%b state=%0d want done=0 idle",
                     done_w[1], dut_a2.state);
        end
    endtask

    task automatic test_no_checksum();
        byte_q_t exp, got;
        int      base;
        bit      ok;
        for (int p = 0; p < 4; p++) begin
            if (p == 0) mem2 = '{8'hFF, 8'h01, 8'h7E, 8'h80};
            else for (int i = 0; i < 4; i++) mem2[i] = 8'($urandom);
            exp = {SYNC_BYTE_DEFAULT};
            for (int i = 0; i < 4; i++) exp.push_back(mem2[i]);
            base   = rx_log.size();
            act[2] = 1'b1;
            wait_done(2, ok);
            repeat (20) @(posedge clk_50mhz);
            #1;
            collect(2, base, got);
            vectors++;
            if (!ok || done_w[2] !== 1'b1 || got.size() != exp.size()) begin
                miscompares++;
                $display("FAIL nocsum_frame[%0d] got done=%b len=%0d want done=1 len=%0d",
                         p, done_w[2], got.size(), exp.size());
            end
            for (int i = 0; i < exp.size() && i < got.size(); i++) begin
                vectors++;
                if (got[i] !== exp[i]) begin
                    miscompares++;
                    $display("FAIL nocsum_byte[%0d.%0d] got %h want %h", p, i, got[i], exp[i]);
                end
            end
            release_act(2);
        end
    endtask

    task automatic test_busy_hold();
        bit seen, ok;
        seen          = 1'b0;
        force_busy[0] = 1'b1;
        act[0]        = 1'b1;
        repeat (500) begin
            @(posedge clk_50mhz);
            #1;
            if (tx_start_w[0]) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_hold got tx_start while busy want none");
        end
        force_busy[0] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_50mhz);
            #1;
            if (tx_start_w[0]) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok || tx_data_w[0] !== SYNC_BYTE_DEFAULT) begin
            miscompares++;
            $display("FAIL busy_first got start=%b data=%h want 1 a5", ok, tx_data_w[0]);
        end
        @(posedge clk_50mhz);
        #1;
        vectors++;
        if (tx_start_w[0] !== 1'b0 || proto_err[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_pulse got start=%b proto_err=%b want 0 0",
                     tx_start_w[0], proto_err[0]);
        end
        wait_done(0, ok);
        release_act(0);
    endtask

    task automatic test_abort_restart();
        byte_q_t got;
        int      base, s;
        bit      ok;
        base   = rx_log.size();
        act[0] = 1'b1;
        ok     = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk_50mhz);
            #1;
            if (rx_log.size() - base >= 3 && tx_done_w[0]) begin
                ok = 1'b1;
                break;
            end
        end
        act[0] = 1'b0;
        repeat (50) @(posedge clk_50mhz);
        #1;
        vectors++;
        if (!ok || rx_log.size() - base != 3 || done_w[0] !== 1'b0 || mem_oe_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort got seen=%b bytes=%0d done=%b oe=%b want 1 3 0 0",
                     ok, rx_log.size() - base, done_w[0], mem_oe_w[0]);
        end
        base   = rx_log.size();
        act[0] = 1'b1;
        wait_done(0, ok);
        collect(0, base, got);
        s = 0;
        for (int i = 0; i < 256; i++) s += int'(mem0[i]);
        vectors++;
        if (!ok || got.size() != 258) begin
            miscompares++;
            $display("FAIL restart_len got done=%b len=%0d want 1 258", ok, got.size());
        end else begin
            for (int i = 0; i < 258; i++) begin
                vectors++;
                if (got[i] !== (i == 0 ? SYNC_BYTE_DEFAULT : i == 257 ? 8'(s % 256) : mem0[i-1])) begin
                    miscompares++;
                    $display("FAIL restart_byte[%0d] got %h", i, got[i]);
                end
            end
        end
        release_act(0);
    endtask

    task automatic test_reset_midframe();
        byte_q_t got;
        int      base, s;
        bit      ok;
        for (int i = 0; i < 256; i++) mem0[i] = 8'($urandom);
        base   = rx_log.size();
        act[0] = 1'b1;
        for (int c = 0; c < 5000 && rx_log.size() - base < 10; c++) @(posedge clk_50mhz);
        @(posedge clk_50mhz);
        #7;
        reset = 1'b0;
        #1;
        vectors++;
        if ({done_w[0], tx_start_w[0], mem_oe_w[0]} !== 3'b000 || mem_addr0 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid got done/start/oe=%b addr=%h want 000 00",
                     {done_w[0], tx_start_w[0], mem_oe_w[0]}, mem_addr0);
        end
        for (int c = 0; c < 50 && busy[0]; c++) @(posedge clk_50mhz);
        repeat (3) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        base  = rx_log.size();
        reset = 1'b1;
        wait_done(0, ok);
        collect(0, base, got);
        s = 0;
        for (int i = 0; i < 256; i++) s += int'(mem0[i]);
        vectors++;
        if (!ok || got.size() != 258) begin
            miscompares++;
            $display("FAIL reset_frame_len got done=%b len=%0d want 1 258", ok, got.size());
        end else begin
            for (int i = 0; i < 258; i++) begin
                vectors++;
                if (got[i] !== (i == 0 ? SYNC_BYTE_DEFAULT : i == 257 ? 8'(s % 256) : mem0[i-1])) begin
                    miscompares++;
                    $display("FAIL reset_frame_byte[%0d] got %h", i, got[i]);
                end
            end
        end
        release_act(0);
    endtask

    initial begin
        act        = '0;
        force_busy = '0;
        for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
        mem1 = '{default: 8'h00};
        mem2 = '{default: 8'h00};
        test_reset();
        test_default_frame(1'b0);
        test_default_frame(1'b1);
        test_small_checksum();
        test_no_checksum();
        test_busy_hold();
        test_abort_restart();
        test_reset_midframe();
        vectors++;
        if (proto_err !== 3'b000) begin
            miscompares++;
            $display("FAIL tx_protocol got err=%b want 000", proto_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1800000;
        $display("FAIL watchdog got no finish want finish before 1.8 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sample_reader.md
Name: sample_reader

Overview:
- Read-side counterpart of `sampler`. After a capture, it reads every address of the sample memory (`ram_sw_ar`, read port) in order and streams the contents to the host over `uart_tx`.
- Frame sent: sync byte, then 2^ADDR_WIDTH samples (address 0 first), then an optional 8-bit checksum.
- Controlled by the top-level state watcher (ST_SAMPLE_READ = 8'h22) through the usual `activate`/`done` pair.
- Its `tx_data`/`tx_start` are multiplexed onto the shared `uart_tx` by the top-level TX manager.

Parameters:
- DATA_WIDTH, 8, sample width; must be 8 (one UART byte per sample).
- ADDR_WIDTH, 8, sample memory address width; samples sent N = 2^ADDR_WIDTH.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- SEND_CHECKSUM, 1, 1 = append checksum byte; 0 = frame ends after the last sample.

Ports:
- clk_50mhz  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset (KEY4).
- activate  in  1  level; high while the state watcher selects this block.
- done  out  1  high from frame completion until `activate` falls.
- mem_addr  out  ADDR_WIDTH  read address to sample memory (registered).
- mem_oe  out  1  read enable to sample memory.
- mem_data  in  DATA_WIDTH  asynchronous read data from sample memory.
- tx_data  out  8  byte to transmit (registered).
- tx_start  out  1  one-cycle start request to `uart_tx`.
- tx_active  in  1  `uart_tx` is busy.
- tx_done  in  1  one-cycle pulse when `uart_tx` finishes a byte.

Behaviour:
- Reset (async, reset=0): state=IDLE; done=0, tx_start=0, tx_data=0, mem_addr=0, mem_oe=0, checksum=0. Any frame in progress is discarded.
- States: IDLE, HDR, HDR_WAIT, FETCH, XMIT, XMIT_WAIT, CSUM, CSUM_WAIT, DONE.
- IDLE: on activate=1 → HDR; clear mem_addr and checksum.
- HDR:
  - Waits while tx_active=1.
  - When tx_active=0: tx_data<=SYNC_BYTE, tx_start=1 for exactly one cycle, → HDR_WAIT.
- HDR_WAIT: on tx_done → FETCH.
- FETCH: mem_oe=1 for one cycle so the asynchronous read settles → XMIT.
- XMIT:
  - mem_oe stays 1. Waits while tx_active=1.
  - When tx_active=0: tx_data<=mem_data; checksum<=checksum+mem_data (mod 256); tx_start=1 for one cycle → XMIT_WAIT.
- XMIT_WAIT: mem_oe=0. On tx_done:
  - if mem_addr == N-1: → CSUM if SEND_CHECKSUM, else → DONE.
  - otherwise mem_addr<=mem_addr+1 → FETCH.
  - mem_addr never wraps inside a frame.
- CSUM: when tx_active=0: tx_data<=checksum, tx_start one cycle → CSUM_WAIT.
- CSUM_WAIT: on tx_done → DONE.
- DONE: done=1; stays here while activate=1. On activate=0 → IDLE with done=0 on the same edge.
- tx_start handshake:
  - Never high for two consecutive cycles.
  - Never re-asserted before the tx_done of the previous byte.
  - The top-level mux adds one cycle of delay, so the *_WAIT states exit only on tx_done, never on tx_active.
- tx_done is ignored outside the *_WAIT states. A tx_done arriving in the same cycle the state is entered counts.
- Abort: activate=0 in any state other than IDLE/DONE → IDLE next cycle.
  - tx_start=0, mem_oe=0, done stays 0.
  - A byte already started in `uart_tx` finishes on its own.
  - Re-activation always begins a fresh frame at address 0.
- Frame length: 1 + N + SEND_CHECKSUM bytes. For defaults: 258 bytes, about 22.4 ms at 115200 baud.
- Checksum: 8-bit unsigned sum of all N samples mod 256. The sync byte is excluded.
- Per-byte overhead beyond UART time: at most 3 clk_50mhz cycles.

Decomposition:
- Shared package `oscilo_pkg` holds:
  - the sample_reader_state_t enum;
  - SYNC_BYTE default (8'hA5);
  - state-watcher codes (ST_SAMPLE_READ = 8'h22 etc.), so main, sampler and reader share one definition.
- One natural sub-module: `uart_byte_sender`. It takes a load request and a byte, waits for tx_active=0, issues a one-cycle tx_start, and reports sent on tx_done. Reusable by replayer/reply_cnt.

Test Plan:
- Default parameters, memory[i]=i, activate held high, UART model at 115200 → bytes A5,00,01,…,FF,80, then done=1; tx_start count = 258.
- ADDR_WIDTH=2, memory={10,20,30,40} → bytes A5,10,20,30,40,A0, then done; drop activate → done=0 next cycle, state IDLE.
- ADDR_WIDTH=2, SEND_CHECKSUM=0, memory={FF,01,7E,80} → bytes A5,FF,01,7E,80 only, then done=1.
- tx_active forced high for 500 cycles at activation → tx_start stays 0 until tx_active falls, then exactly one pulse with tx_data=A5.
- Drop activate after the third byte's tx_done → no further tx_start, done stays 0. Re-raise activate → frame restarts with A5 and mem_addr=0.
- Assert reset mid-frame (asynchronously, between clock edges) → done, tx_start, mem_oe, mem_addr go 0 immediately. After release with activate=1 → clean full frame from A5.
